// File: rtl/simmem_pkg.sv
// Shared types and constants for the simulated memory write path.
//   waddr_req_t : write address request {id, addr, burst_length}
//   wdata_req_t : write data beat {id, data, last}
//   wresp_t     : write response {id, content}
package simmem_pkg;

    localparam int unsigned IdWidth     = 4;
    localparam int unsigned AxAddrWidth = 8;
    localparam int unsigned AxLenWidth  = 4;
    localparam int unsigned DataWidth   = 32;
    localparam int unsigned XRespWidth  = 3;

    localparam logic [XRespWidth-1:0] XRespOkay   = 3'b000;
    localparam logic [XRespWidth-1:0] XRespSlvErr = 3'b010;

    typedef struct packed {
        logic [IdWidth-1:0]     id;
        logic [AxAddrWidth-1:0] addr;
        logic [AxLenWidth-1:0]  burst_length;
    } waddr_req_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic                 last;
    } wdata_req_t;

    typedef struct packed {
        logic [IdWidth-1:0]    id;
        logic [XRespWidth-1:0] content;
    } wresp_t;

    localparam int unsigned WriteAddrReqWidth = $bits(waddr_req_t);
    localparam int unsigned WriteRespWidth    = $bits(wresp_t);

    typedef enum logic {
        WAIT_ADDR,
        RECV_DATA
    } wresp_fsm_e;

endpackage

// File: rtl/simmem_sync_fifo.sv
// Synchronous FIFO with registered storage; the head entry is read straight
// out of the storage array, so a push into an empty FIFO appears on data_o
// the following cycle.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i/data_i: write request (dropped when full unless popping the same cycle)
//   pop_i        : remove head (caller guarantees non-empty)
//   data_o       : head entry
//   count_o      : current fill level (0..Depth)
module simmem_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    cnt_q;
    logic             full, empty, do_push, do_pop;

    assign full    = (cnt_q == (PtrW+1)'(Depth));
    assign empty   = (cnt_q == '0);
    // Push into a full FIFO is legal only when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/simmem_wresp_responder.sv
// Memory-side AXI write responder. Queues write addresses, consumes data
// beats for the burst at the head of the address queue and returns one
// response per closed burst, in address-acceptance order.
//   waddr_i/_valid_i/_ready_o : write address channel
//   wdata_i/_valid_i/_ready_o : write data channel
//   wresp_o/_valid_o/_ready_i : write response channel {id, content}
//   burst_err_o               : 1-cycle pulse after a burst closes with a
//                               length or id mismatch
module simmem_wresp_responder
    import simmem_pkg::*;
#(
    parameter int unsigned            AddrQueueDepth = 4,
    parameter int unsigned            RespQueueDepth = 4,
    parameter logic [AxAddrWidth-1:0] ErrAddrBase    = 8'hF0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  waddr_req_t                waddr_i,
    input  logic                      waddr_in_valid_i,
    output logic                      waddr_in_ready_o,
    input  wdata_req_t                wdata_i,
    input  logic                      wdata_in_valid_i,
    output logic                      wdata_in_ready_o,
    output logic [WriteRespWidth-1:0] wresp_o,
    output logic                      wresp_out_valid_o,
    input  logic                      wresp_out_ready_i,
    output logic                      burst_err_o
);

    localparam int unsigned AcW = $clog2(AddrQueueDepth) + 1;
    localparam int unsigned RcW = $clog2(RespQueueDepth) + 1;

    wresp_fsm_e               state_q, state_d;
    logic [AxLenWidth-1:0]    beat_cnt_q, beat_cnt_d;
    logic                     id_err_q, id_err_d;
    logic                     burst_err_q, burst_err_d;

    logic [WriteAddrReqWidth-1:0] head_raw;
    waddr_req_t               head;
    logic [AcW-1:0]           addr_cnt;
    logic [RcW-1:0]           resp_cnt;
    logic                     addr_full, addr_empty, resp_full, resp_empty;
    logic                     addr_push, beat_acc, close, resp_pop;
    logic                     id_mis, len_mis, addr_err;
    wresp_t                   resp_new;

    assign head       = waddr_req_t'(head_raw);
    assign addr_full  = (addr_cnt == AcW'(AddrQueueDepth));
    assign addr_empty = (addr_cnt == '0);
    assign resp_full  = (resp_cnt == RcW'(RespQueueDepth));
    assign resp_empty = (resp_cnt == '0);

    assign waddr_in_ready_o  = !rst_i && !addr_full;
    assign wdata_in_ready_o  = !rst_i && (state_q == RECV_DATA) && !resp_full;
    assign wresp_out_valid_o = !rst_i && !resp_empty;
    assign burst_err_o       = burst_err_q;

    assign addr_push = waddr_in_valid_i && waddr_in_ready_o;
    assign beat_acc  = wdata_in_valid_i && wdata_in_ready_o;
    assign close     = beat_acc && wdata_i.last;
    assign resp_pop  = wresp_out_valid_o && wresp_out_ready_i;

    assign id_mis   = (wdata_i.id != head.id);
    assign len_mis  = (beat_cnt_q != head.burst_length);
    assign addr_err = (head.addr >= ErrAddrBase);

    always_comb begin
        resp_new.id      = head.id;
        resp_new.content = (addr_err || len_mis || id_err_q || id_mis) ? XRespSlvErr : XRespOkay;
    end

    simmem_sync_fifo #(
        .Width (WriteAddrReqWidth),
        .Depth (AddrQueueDepth)
    ) u_addr_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (addr_push),
        .data_i  (waddr_i),
        .pop_i   (close),
        .data_o  (head_raw),
        .count_o (addr_cnt)
    );

    simmem_sync_fifo #(
        .Width (WriteRespWidth),
        .Depth (RespQueueDepth)
    ) u_resp_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (close),
        .data_i  (resp_new),
        .pop_i   (resp_pop),
        .data_o  (wresp_o),
        .count_o (resp_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= WAIT_ADDR;
            beat_cnt_q  <= '0;
            id_err_q    <= 1'b0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            id_err_q    <= id_err_d;
            burst_err_q <= burst_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        id_err_d    = id_err_q;
        burst_err_d = 1'b0;
        unique case (state_q)
            WAIT_ADDR: begin
                if (!addr_empty) begin
                    state_d    = RECV_DATA;
                    beat_cnt_d = '0;
                end
            end
            RECV_DATA: begin
                if (close) begin
                    beat_cnt_d  = '0;
                    id_err_d    = 1'b0;
                    burst_err_d = len_mis || id_err_q || id_mis;
                    // Another head remains if more than one entry was queued
                    // or a new address lands in the same cycle as the pop.
                    state_d = ((addr_cnt > AcW'(1)) || addr_push) ? RECV_DATA : WAIT_ADDR;
                end else if (beat_acc) begin
                    beat_cnt_d = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 1'b1;
                    id_err_d   = id_err_q || id_mis;
                end
            end
            default: state_d = WAIT_ADDR;
        endcase
    end

endmodule

// File: tb/tb_simmem_wresp_responder.sv
module tb_simmem_wresp_responder;
    import simmem_pkg::*;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    waddr_req_t                waddr_i;
    logic                      waddr_in_valid_i;
    logic                      waddr_in_ready_o;
    wdata_req_t                wdata_i;
    logic                      wdata_in_valid_i;
    logic                      wdata_in_ready_o;
    logic [WriteRespWidth-1:0] wresp_o;
    logic                      wresp_out_valid_o;
    logic                      wresp_out_ready_i;
    logic                      burst_err_o;

    int n_cmp = 0;
    int n_err = 0;

    simmem_wresp_responder dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .waddr_i           (waddr_i),
        .waddr_in_valid_i  (waddr_in_valid_i),
        .waddr_in_ready_o  (waddr_in_ready_o),
        .wdata_i           (wdata_i),
        .wdata_in_valid_i  (wdata_in_valid_i),
        .wdata_in_ready_o  (wdata_in_ready_o),
        .wresp_o           (wresp_o),
        .wresp_out_valid_o (wresp_out_valid_o),
        .wresp_out_ready_i (wresp_out_ready_i),
        .burst_err_o       (burst_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rsp(input int id, input int content);
        logic [31:0] r;
        r = (id << 3) | content;
        return r;
    endfunction

    task automatic send_addr(input int id, input int addr, input int len);
        int w;
        waddr_i.id           = IdWidth'(id);
        waddr_i.addr         = AxAddrWidth'(addr);
        waddr_i.burst_length = AxLenWidth'(len);
        waddr_in_valid_i     = 1'b1;
        w = 0;
        while (!waddr_in_ready_o && w < 20) begin tick(); w++; end
        if (w >= 20) chk("waddr_timeout", 32'd1, 32'd0);
        tick();
        waddr_in_valid_i = 1'b0;
    endtask

    task automatic send_beat(input int id, input logic last);
        int w;
        wdata_i.id       = IdWidth'(id);
        wdata_i.data     = $urandom;
        wdata_i.last     = last;
        wdata_in_valid_i = 1'b1;
        w = 0;
        while (!wdata_in_ready_o && w < 20) begin tick(); w++; end
        if (w >= 20) chk("wdata_timeout", 32'd1, 32'd0);
        tick();
        wdata_in_valid_i = 1'b0;
    endtask

    initial begin
        rst_i             = 1'b1;
        waddr_i           = '0;
        waddr_in_valid_i  = 1'b0;
        wdata_i           = '0;
        wdata_in_valid_i  = 1'b0;
        wresp_out_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_waddr_rdy", 32'(waddr_in_ready_o), 0);
        chk("rst_wdata_rdy", 32'(wdata_in_ready_o), 0);
        chk("rst_valid",     32'(wresp_out_valid_o), 0);
        chk("rst_berr",      32'(burst_err_o), 0);
        rst_i = 1'b0;
        #1;
        chk("idle_waddr_rdy", 32'(waddr_in_ready_o), 1);
        chk("idle_wdata_rdy", 32'(wdata_in_ready_o), 0);

        // Single-beat write
        send_addr(3, 'h10, 0);
        send_beat(3, 1'b1);
        chk("t1_valid", 32'(wresp_out_valid_o), 1);
        chk("t1_resp",  32'(wresp_o), rsp(3, 0));
        chk("t1_berr",  32'(burst_err_o), 0);
        wresp_out_ready_i = 1'b1; tick(); wresp_out_ready_i = 1'b0;
        chk("t1_drained", 32'(wresp_out_valid_o), 0);

        // 4-beat burst, response held under back-pressure
        send_addr(5, 'h20, 3);
        send_beat(5, 1'b0);
        send_beat(5, 1'b0);
        send_beat(5, 1'b0);
        chk("t2_no_resp_yet", 32'(wresp_out_valid_o), 0);
        send_beat(5, 1'b1);
        chk("t2_valid", 32'(wresp_out_valid_o), 1);
        chk("t2_resp",  32'(wresp_o), rsp(5, 0));
        tick(); tick();
        chk("t2_valid_held", 32'(wresp_out_valid_o), 1);
        chk("t2_resp_held",  32'(wresp_o), rsp(5, 0));
        wresp_out_ready_i = 1'b1; tick(); wresp_out_ready_i = 1'b0;
        chk("t2_taken", 32'(wresp_out_valid_o), 0);

        // Early last: length error
        send_addr(6, 'h20, 3);
        send_beat(6, 1'b0);
        send_beat(6, 1'b1);
        chk("t3_resp", 32'(wresp_o), rsp(6, 2));
        chk("t3_berr", 32'(burst_err_o), 1);
        tick();
        chk("t3_berr_pulse", 32'(burst_err_o), 0);
        wresp_out_ready_i = 1'b1; tick(); wresp_out_ready_i = 1'b0;
        send_addr(7, 'h30, 1);
        send_beat(7, 1'b0);
        send_beat(7, 1'b1);
        chk("t3_clean_resp", 32'(wresp_o), rsp(7, 0));
        chk("t3_clean_berr", 32'(burst_err_o), 0);
        wresp_out_ready_i = 1'b1; tick(); wresp_out_ready_i = 1'b0;

        // Address error boundary
        send_addr(1, 'hF4, 0);
        send_beat(1, 1'b1);
        chk("t4_f4_resp", 32'(wresp_o), rsp(1, 2));
        chk("t4_f4_berr", 32'(burst_err_o), 0);
        wresp_out_ready_i = 1'b1; tick(); wresp_out_ready_i = 1'b0;
        send_addr(2, 'hEF, 0);
        send_beat(2, 1'b1);
        chk("t4_ef_resp", 32'(wresp_o), rsp(2, 0));
        wresp_out_ready_i = 1'b1; tick(); wresp_out_ready_i = 1'b0;
        send_addr(9, 'hF0, 0);
        send_beat(9, 1'b1);
        chk("t4_f0_resp", 32'(wresp_o), rsp(9, 2));
        wresp_out_ready_i = 1'b1; tick(); wresp_out_ready_i = 1'b0;

        // Beat id mismatch
        send_addr(4, 'h11, 0);
        send_beat(10, 1'b1);
        chk("t4_id_resp", 32'(wresp_o), rsp(4, 2));
        chk("t4_id_berr", 32'(burst_err_o), 1);
        wresp_out_ready_i = 1'b1; tick(); wresp_out_ready_i = 1'b0;

        // Fill address queue, then drain in order
        for (int i = 0; i < 4; i++) send_addr(8 + i, 'h40, 0);
        chk("t5_addr_full", 32'(waddr_in_ready_o), 0);
        waddr_i.id = 4'd1; waddr_in_valid_i = 1'b1;
        tick();
        chk("t5_5th_refused", 32'(waddr_in_ready_o), 0);
        waddr_in_valid_i = 1'b0;
        wresp_out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_beat(8 + i, 1'b1);
            chk("t5_drain_valid", 32'(wresp_out_valid_o), 1);
            chk("t5_drain_resp",  32'(wresp_o), rsp(8 + i, 0));
        end
        tick();
        wresp_out_ready_i = 1'b0;
        chk("t5_empty_valid", 32'(wresp_out_valid_o), 0);
        chk("t5_addr_rdy",    32'(waddr_in_ready_o), 1);

        // Response queue full stalls data, then reset mid-burst
        for (int i = 0; i < 4; i++) begin
            send_addr(12 + i, 'h50, 0);
            send_beat(12 + i, 1'b1);
        end
        send_addr(1, 'h60, 3);
        tick(); tick();
        chk("t6_resp_full_stall", 32'(wdata_in_ready_o), 0);
        chk("t6_head_resp",       32'(wresp_o), rsp(12, 0));
        wresp_out_ready_i = 1'b1; tick(); wresp_out_ready_i = 1'b0;
        chk("t6_next_resp",   32'(wresp_o), rsp(13, 0));
        chk("t6_unstalled",   32'(wdata_in_ready_o), 1);
        send_beat(1, 1'b0);
        rst_i = 1'b1;
        #1;
        chk("t6_rst_valid",     32'(wresp_out_valid_o), 0);
        chk("t6_rst_waddr_rdy", 32'(waddr_in_ready_o), 0);
        chk("t6_rst_wdata_rdy", 32'(wdata_in_ready_o), 0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("t6_post_valid",     32'(wresp_out_valid_o), 0);
        chk("t6_post_waddr_rdy", 32'(waddr_in_ready_o), 1);
        chk("t6_post_wdata_rdy", 32'(wdata_in_ready_o), 0);
        chk("t6_post_berr",      32'(burst_err_o), 0);
        tick();
        chk("t6_no_stale_head", 32'(wdata_in_ready_o), 0);
        send_addr(3, 'h10, 0);
        send_beat(3, 1'b1);
        chk("t6_after_rst_resp", 32'(wresp_o), rsp(3, 0));
        chk("t6_after_rst_vld",  32'(wresp_out_valid_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
